// File: rtl/aes0_job_master.sv
// aes0_job_master: runs one AES0 encryption job over the register bus.
// Optional AES0_KEY_CACHE_EN skips key writes when slot and key repeat.
module aes0_job_master #(
   parameter int POLL_TIMEOUT = 1024,
   parameter int ADDR_W       = 9
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [127:0]      req_pt_i,
   input  logic [191:0]      req_key_i,
   input  logic [1:0]        req_slot_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [127:0]      resp_ct_o,
   output logic              resp_err_o,
   output logic              bus_en_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [63:0]       bus_wdata_o,
   input  logic [63:0]       bus_rdata_i
);

   localparam int WORD_W = ADDR_W - 3;
   localparam int CLOG_T = $clog2(POLL_TIMEOUT + 1);
   localparam int CNT_W  = (CLOG_T > 11) ? CLOG_T : 11;

   localparam logic [CNT_W-1:0]  CNT_MAX = '1;
   localparam logic [CNT_W-1:0]  CNT_LIM = CNT_W'(POLL_TIMEOUT);
   localparam logic [WORD_W-1:0] W_START = WORD_W'(0);
   localparam logic [WORD_W-1:0] W_PT    = WORD_W'(1);
   localparam logic [WORD_W-1:0] W_STAT  = WORD_W'(11);
   localparam logic [WORD_W-1:0] W_CT    = WORD_W'(12);
   localparam logic [WORD_W-1:0] W_SEL   = WORD_W'(32);

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_PT,
      S_WR_KEY,
      S_WR_SEL,
      S_WR_START,
      S_POLL,
      S_RD_CT,
      S_CLR_START,
      S_RESP
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic               err_q, err_d;
   logic [127:0]       pt_q;
   logic [191:0]       key_q;
   logic [1:0]         slot_q;
   logic [127:0]       ct_q;
   logic               accept;
   logic               key_hit;
   logic [WORD_W-1:0]  word;
   logic [WORD_W-1:0]  key_base;
   logic [31:0]        wdata;
   logic               unused_rdata;

   assign unused_rdata = ^bus_rdata_i[63:32];

   always_comb begin
      key_base = WORD_W'(26);
      unique case (slot_q)
         2'd0:    key_base = WORD_W'(5);
         2'd1:    key_base = WORD_W'(20);
         default: key_base = WORD_W'(26);
      endcase
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      accept   = 1'b0;
      bus_en_o = 1'b0;
      bus_we_o = 1'b0;
      word     = '0;
      wdata    = 32'h0;
      cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      unique case (state_q)
         S_IDLE: begin
            if (req_valid_i && rst_ni) begin
               accept = 1'b1;
               idx_d  = 3'd0;
               err_d  = (req_slot_i == 2'd3);
               state_d = (req_slot_i == 2'd3) ? S_RESP : S_WR_PT;
            end
         end
         S_WR_PT: begin
            bus_en_o = 1'b1;
            bus_we_o = 1'b1;
            word     = W_PT + WORD_W'(idx_q);
            wdata    = pt_q[32*idx_q[1:0] +: 32];
            if (idx_q == 3'd3) begin
               idx_d   = 3'd0;
               state_d = key_hit ? S_WR_SEL : S_WR_KEY;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         S_WR_KEY: begin
            bus_en_o = 1'b1;
            bus_we_o = 1'b1;
            word     = key_base + WORD_W'(idx_q);
            wdata    = key_q[32*idx_q +: 32];
            if (idx_q == 3'd5) begin
               idx_d   = 3'd0;
               state_d = S_WR_SEL;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         S_WR_SEL: begin
            bus_en_o = 1'b1;
            bus_we_o = 1'b1;
            word     = W_SEL;
            wdata    = {30'h0, slot_q};
            state_d  = S_WR_START;
         end
         S_WR_START: begin
            bus_en_o = 1'b1;
            bus_we_o = 1'b1;
            word     = W_START;
            wdata    = 32'h1;
            cnt_d    = '0;
            state_d  = S_POLL;
         end
         S_POLL: begin
            bus_en_o = 1'b1;
            word     = W_STAT;
            if (bus_rdata_i[0]) begin
               idx_d   = 3'd0;
               state_d = S_RD_CT;
            end else begin
               cnt_d = cnt_inc;
               // ct_valid still low after the last permitted poll: give up
               if (cnt_inc >= CNT_LIM) begin
                  err_d   = 1'b1;
                  state_d = S_CLR_START;
               end
            end
         end
         S_RD_CT: begin
            bus_en_o = 1'b1;
            word     = W_CT + WORD_W'(idx_q);
            if (idx_q == 3'd3) begin
               idx_d   = 3'd0;
               state_d = S_CLR_START;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         S_CLR_START: begin
            bus_en_o = 1'b1;
            bus_we_o = 1'b1;
            word     = W_START;
            wdata    = 32'h0;
            state_d  = S_RESP;
         end
         S_RESP: begin
            if (resp_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         idx_q   <= 3'd0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pt_q   <= '0;
         key_q  <= '0;
         slot_q <= 2'd0;
         ct_q   <= '0;
      end else if (accept) begin
         pt_q   <= req_pt_i;
         key_q  <= req_key_i;
         slot_q <= req_slot_i;
         ct_q   <= '0;
      end else if (state_q == S_RD_CT) begin
         ct_q[32*idx_q[1:0] +: 32] <= bus_rdata_i[31:0];
      end
   end

`ifdef AES0_KEY_CACHE_EN
   logic         cache_vld_q;
   logic [1:0]   cache_slot_q;
   logic [191:0] cache_key_q;

   assign key_hit = cache_vld_q && (cache_slot_q == slot_q) &&
                    (cache_key_q == key_q);

   // any error response leaves slot contents unknown, so drop the entry
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cache_vld_q  <= 1'b0;
         cache_slot_q <= 2'd0;
         cache_key_q  <= '0;
      end else if (state_q == S_WR_KEY && idx_q == 3'd5) begin
         cache_vld_q  <= 1'b1;
         cache_slot_q <= slot_q;
         cache_key_q  <= key_q;
      end else if (state_q == S_RESP && err_q) begin
         cache_vld_q  <= 1'b0;
      end
   end
`else
   assign key_hit = 1'b0;
`endif

   assign bus_addr_o   = {word, 3'b000};
   assign bus_wdata_o  = {32'h0, wdata};
   assign req_ready_o  = (state_q == S_IDLE) && rst_ni;
   assign resp_valid_o = (state_q == S_RESP);
   assign resp_err_o   = resp_valid_o && err_q;
   assign resp_ct_o    = (resp_valid_o && !err_q) ? ct_q : '0;

endmodule

// File: tb/tb_aes0_job_master.sv
// tb_aes0_job_master: table, hand-written and random jobs against a
// transaction-level model of the AES0 bus sequence (cache-aware).
module tb_aes0_job_master;

   localparam int PT_LIM = 16;
`ifdef AES0_KEY_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic         req_valid_i = 1'b0;
   logic         req_ready_o;
   logic [127:0] req_pt_i = '0;
   logic [191:0] req_key_i = '0;
   logic [1:0]   req_slot_i = '0;
   logic         resp_valid_o;
   logic         resp_ready_i = 1'b0;
   logic [127:0] resp_ct_o;
   logic         resp_err_o;
   logic         bus_en_o;
   logic         bus_we_o;
   logic [8:0]   bus_addr_o;
   logic [63:0]  bus_wdata_o;
   logic [63:0]  bus_rdata_i;

   aes0_job_master #(.POLL_TIMEOUT(PT_LIM), .ADDR_W(9)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_pt_i(req_pt_i), .req_key_i(req_key_i), .req_slot_i(req_slot_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
      .resp_ct_o(resp_ct_o), .resp_err_o(resp_err_o),
      .bus_en_o(bus_en_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
      .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic        we;
      logic [8:0]  addr;
      logic [63:0] wdata;
   } tr_t;

   typedef struct {
      logic [127:0] pt;
      logic [191:0] key;
      logic [1:0]   slot;
      int           polls;
      logic [127:0] ct;
      int           hold;
      int           lat;
      logic         err;
   } vec_t;

   tr_t          trace[$];
   int           checks = 0;
   int           failures = 0;
   int           polls_seen = 0;
   int           poll_base = 0;
   int           poll_target = 0;
   logic [127:0] ct_words = '0;
   int           rd_k;

   bit           c_vld = 1'b0;
   logic [1:0]   c_slot = '0;
   logic [191:0] c_key = '0;

   always @(negedge clk_i)
      if (bus_en_o)
         trace.push_back({bus_we_o, bus_addr_o, bus_we_o ? bus_wdata_o : 64'h0});

   always @(posedge clk_i)
      if (rst_ni && bus_en_o && !bus_we_o && bus_addr_o == 9'd88)
         polls_seen <= polls_seen + 1;

   // Bus slave: status word has junk in bit 1 so only bit 0 may matter
   always_comb begin
      bus_rdata_i = 64'h0;
      rd_k = int'(bus_addr_o[8:3]) - 12;
      if (bus_en_o && !bus_we_o) begin
         if (bus_addr_o == 9'd88)
            bus_rdata_i = {32'hA5A5_0000, 31'h1,
               (poll_target != 0) && (polls_seen - poll_base + 1 >= poll_target)};
         else if (rd_k >= 0 && rd_k < 4)
            bus_rdata_i = {32'hDEAD_BEEF, ct_words[32*rd_k +: 32]};
      end
   end

   task automatic chk(input string name, input logic [191:0] act,
                      input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int kbase(input logic [1:0] s);
      return (s == 2'd0) ? 5 : (s == 2'd1) ? 20 : 26;
   endfunction

   task automatic run_job(input logic [127:0] pt, input logic [191:0] key,
         input logic [1:0] slot, input int polls, input logic [127:0] ct,
         input int hold, output int lat, output logic err);
      tr_t          exp_q[$];
      bit           hit, tmo, e_err, stable;
      int           np, elat, base, n, bad;
      logic [127:0] ect;
      hit   = CACHE && c_vld && c_slot == slot && c_key == key && slot != 2'd3;
      tmo   = (polls == 0) || (polls > PT_LIM);
      np    = tmo ? PT_LIM : polls;
      e_err = (slot == 2'd3) || tmo;
      ect   = e_err ? 128'h0 : ct;
      if (slot == 2'd3) begin
         elat = 1;
      end else begin
         for (int i = 0; i < 4; i++)
            exp_q.push_back({1'b1, 9'((1 + i) * 8), {32'h0, pt[32*i +: 32]}});
         if (!hit)
            for (int i = 0; i < 6; i++)
               exp_q.push_back({1'b1, 9'((kbase(slot) + i) * 8),
                                {32'h0, key[32*i +: 32]}});
         exp_q.push_back({1'b1, 9'd256, {62'h0, slot}});
         exp_q.push_back({1'b1, 9'd0, 64'h1});
         for (int i = 0; i < np; i++) exp_q.push_back({1'b0, 9'd88, 64'h0});
         if (!tmo)
            for (int i = 0; i < 4; i++)
               exp_q.push_back({1'b0, 9'((12 + i) * 8), 64'h0});
         exp_q.push_back({1'b1, 9'd0, 64'h0});
         elat = 1 + 4 + (hit ? 0 : 6) + 2 + np + (tmo ? 0 : 4) + 1;
      end
      if (e_err) c_vld = 1'b0;
      else if (!hit) begin
         c_vld = 1'b1; c_slot = slot; c_key = key;
      end

      ct_words = ct; poll_target = polls; poll_base = polls_seen;
      base = trace.size();
      @(posedge clk_i); #1;
      req_pt_i = pt; req_key_i = key; req_slot_i = slot; req_valid_i = 1'b1;
      n = 0;
      do begin @(negedge clk_i); n++; end while (!req_ready_o && n < 20);
      chk("req_ready_wait", req_ready_o, 1);
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      lat = 0;
      do begin @(negedge clk_i); lat++; end while (!resp_valid_o && lat < 200);
      chk("latency", lat, elat);
      chk("resp_valid", resp_valid_o, 1);
      chk("resp_err", resp_err_o, e_err);
      chk("resp_ct", resp_ct_o, ect);
      chk("req_ready_in_resp", req_ready_o, 0);
      err = resp_err_o;
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk_i);
         if (!resp_valid_o || resp_ct_o !== ect || resp_err_o !== e_err ||
             req_ready_o || bus_en_o) stable = 1'b0;
      end
      if (hold > 0) chk("resp_hold_stable", stable, 1);
      resp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      resp_ready_i = 1'b0;
      @(negedge clk_i);
      chk("idle_after_resp", {resp_valid_o, req_ready_o}, 2'b01);
      chk("trace_len", trace.size() - base, exp_q.size());
      bad = -1;
      for (int i = 0; i < exp_q.size() && base + i < trace.size(); i++)
         if (bad < 0 && trace[base+i] !== exp_q[i]) bad = i;
      checks++;
      if (bad >= 0) begin
         failures++;
         $display("FAIL bus_trace[%0d]: got we=%b addr=%0h wdata=%0h expected we=%b addr=%0h wdata=%0h",
            bad, trace[base+bad].we, trace[base+bad].addr, trace[base+bad].wdata,
            exp_q[bad].we, exp_q[bad].addr, exp_q[bad].wdata);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         tbl[7];
      int           lat, lat2, n, pslot;
      logic         err;
      logic [191:0] pkey, k;
      logic [1:0]   s;

      tbl[0] = '{128'h00112233_44556677_8899aabb_ccddeeff, 192'h17, 2'd0, 3,
                 128'h0f0e0d0c_0b0a0908_07060504_03020100, 0, 21, 1'b0};
      tbl[1] = '{128'h11111111_22222222_33333333_44444444,
                 192'h2a2a_0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa,
                 2'd2, 1, 128'hcafef00d_12345678_9abcdef0_0badc0de, 0, 19, 1'b0};
      tbl[2] = '{128'h5, 192'h5, 2'd3, 1, 128'h1, 0, 1, 1'b1};
      tbl[3] = '{128'hface, 192'h44, 2'd1, 0, 128'h77, 0, 30, 1'b1};
      tbl[4] = '{128'hbeef, 192'h55, 2'd1, 16, 128'h1234_5678_9abc_def0, 0, 34, 1'b0};
      tbl[5] = '{128'hfeed, 192'h66, 2'd0, 17, 128'h99, 0, 30, 1'b1};
      tbl[6] = '{128'h0123, 192'h77, 2'd0, 2, 128'hffff_0000_aaaa_5555, 5, 20, 1'b0};

      repeat (2) @(negedge clk_i);
      chk("reset_outputs", {req_ready_o, resp_valid_o, resp_err_o, bus_en_o,
                            bus_we_o, bus_addr_o, bus_wdata_o, resp_ct_o}, 0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("ready_first_idle", req_ready_o, 1);

      for (int i = 0; i < 7; i++) begin
         run_job(tbl[i].pt, tbl[i].key, tbl[i].slot, tbl[i].polls, tbl[i].ct,
                 tbl[i].hold, lat, err);
         chk("tbl_lat", lat, tbl[i].lat);
         chk("tbl_err", err, tbl[i].err);
      end

      // reset in the middle of the key writes
      poll_target = 1; poll_base = polls_seen;
      @(posedge clk_i); #1;
      req_pt_i = 128'h9; req_key_i = 192'h9; req_slot_i = 2'd1; req_valid_i = 1'b1;
      n = 0;
      do begin @(negedge clk_i); n++; end while (!req_ready_o && n < 20);
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      repeat (5) @(posedge clk_i);
      #2;
      chk("midjob_bus_en_before", bus_en_o, 1);
      rst_ni = 1'b0;
      c_vld = 1'b0;
      #1;
      chk("midjob_bus_en_reset", bus_en_o, 0);
      n = trace.size();
      repeat (3) @(negedge clk_i);
      chk("midjob_no_strobes", trace.size() - n, 0);
      chk("midjob_no_resp", {resp_valid_o, req_ready_o}, 0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      run_job(128'h1357_9bdf, 192'habc, 2'd1, 1, 128'h2468, 0, lat, err);

      // repeated slot and key
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_job(128'h1, k, 2'd2, 1, 128'h11, 0, lat, err);
      run_job(128'h2, k, 2'd2, 1, 128'h22, 0, lat2, err);
      chk("cache_second_latency", lat2, CACHE ? 13 : 19);

      pkey = k; pslot = 2;
      for (int j = 0; j < 24; j++) begin
         if ($urandom_range(0, 2) == 0) begin
            k = pkey; s = 2'(pslot);
         end else begin
            k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            s = 2'($urandom_range(0, 3));
         end
         run_job({$urandom, $urandom, $urandom, $urandom}, k, s,
                 $urandom_range(0, 18), {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 3), lat, err);
         pkey = k; pslot = int'(s);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
